row_encoder: RTL

- Collects active-low row request lines and serialises them into 3-bit row addresses using a valid/ready handshake.
- Fills the opposite role to the 3-to-8 active-low row decoder: that block turns an address into an active-low one-hot row select, and this block turns active-low row activity back into an address.
- Its `addr`/`nen` outputs are pin-compatible with the decoder inputs, so the two blocks form a loopback pair.

---
 rtl/row_encoder_pkg.sv | 20 ++
 rtl/row_encoder_if.sv | 38 +++
 rtl/row_encoder_prio_pick.sv | 35 +++
 rtl/row_encoder.sv | 97 +++++++++
 4 files changed

// File: rtl/row_encoder_pkg.sv
// ============================================================================
// Module  : row_encoder_pkg
// Purpose : Shared state enum and sizing constants for the row encoder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package row_encoder_pkg;

    localparam int ROWS   = 8;
    localparam int ADDR_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage : row_encoder_pkg

`default_nettype wire

// File: rtl/row_encoder_if.sv
// ============================================================================
// Module  : row_encoder_if
// Purpose : Request lines, grant handshake and pending status of the encoder.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface row_encoder_if;
    import row_encoder_pkg::*;

    logic [ROWS-1:0]   row_req_n;
    logic [ADDR_W-1:0] addr;
    logic              valid;
    logic              ready;
    logic              nen;
    logic [ROWS-1:0]   pend;

    modport master (
        input  row_req_n,
        input  ready,
        output addr,
        output valid,
        output nen,
        output pend
    );

    modport slave (
        output row_req_n,
        output ready,
        input  addr,
        input  valid,
        input  nen,
        input  pend
    );

endinterface : row_encoder_if

`default_nettype wire

// File: rtl/row_encoder_prio_pick.sv
// ============================================================================
// Module  : prio_pick
// Purpose : Combinational circular priority search starting at start_i.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module prio_pick
    import row_encoder_pkg::*;
(
    input  logic [ROWS-1:0]   req_i,
    input  logic [ADDR_W-1:0] start_i,
    output logic [ADDR_W-1:0] idx_o,
    output logic              any_o
);

    logic [ADDR_W-1:0] pos;

    // Walk offsets from farthest to nearest so the nearest hit overwrites.
    always_comb begin
        idx_o = '0;
        pos   = '0;
        for (int k = ROWS - 1; k >= 0; k--) begin
            pos = start_i + k[ADDR_W-1:0];
            if (req_i[pos]) begin
                idx_o = pos;
            end
        end
    end

    assign any_o = |req_i;

endmodule : prio_pick

`default_nettype wire

// File: rtl/row_encoder.sv
// ============================================================================
// Module  : row_encoder
// Purpose : Sticky active-low row requests serialised into 3-bit addresses.
//           Define ROW_ENCODER_RR_EN for round-robin selection.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module row_encoder
    import row_encoder_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    row_encoder_if.master bus
);

    state_t            state_q;
    logic [ROWS-1:0]   pend_q;
    logic [ROWS-1:0]   pend_d;
    logic [ROWS-1:0]   clr;
    logic [ADDR_W-1:0] addr_q;
    logic              valid_q;
    logic              nen_q;
    logic [ADDR_W-1:0] start;
    logic [ADDR_W-1:0] pick_idx;
    logic              pick_any;
    logic              accept;

`ifdef ROW_ENCODER_RR_EN
    logic [ADDR_W-1:0] last_q;
    assign start = last_q + 3'd1;
`else
    assign start = '0;
`endif

    assign accept = (state_q == OFFER) && bus.ready;

    // Set is OR-ed in after the clear so a request on the granted row survives.
    always_comb begin
        clr = '0;
        if (accept) begin
            clr[addr_q] = 1'b1;
        end
        pend_d = (pend_q & ~clr) | ~bus.row_req_n;
    end

    prio_pick u_pick (
        .req_i   (pend_q),
        .start_i (start),
        .idx_o   (pick_idx),
        .any_o   (pick_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            addr_q  <= '0;
            valid_q <= 1'b0;
            nen_q   <= 1'b1;
`ifdef ROW_ENCODER_RR_EN
            last_q  <= 3'd7;
`endif
        end else begin
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        addr_q  <= pick_idx;
                        valid_q <= 1'b1;
                        nen_q   <= 1'b0;
                        state_q <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.ready) begin
                        valid_q <= 1'b0;
                        nen_q   <= 1'b1;
                        state_q <= IDLE;
`ifdef ROW_ENCODER_RR_EN
                        last_q  <= addr_q;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.addr  = addr_q;
    assign bus.valid = valid_q;
    assign bus.nen   = nen_q;
    assign bus.pend  = pend_q;

endmodule : row_encoder

`default_nettype wire
